// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - parametrised data-memory controller with wait states and error reporting
//
// Purpose: word-organised data memory behind a valid/ready request/response
// handshake, one transaction in flight, per-byte write enables, WAIT wait
// states between acceptance and the array access, misaligned/out-of-range
// error reporting.
//
// Ports:
//   clk        - rising-edge clock
//   reset      - asynchronous active-low reset
//   req_valid  - request present            req_ready  - request can be accepted
//   req_we     - 1 = write, 0 = read        req_addr   - byte address
//   req_wdata  - write data                 req_be     - byte enables (writes only)
//   resp_valid - response present           resp_ready - consumer takes the response
//   resp_rdata - read data (0 for writes and errors)
//   resp_err   - misaligned or out-of-range access
module dmem_ctrl #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32,
  parameter int WAIT   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH * BYTES);

  typedef enum logic [1:0] {IDLE, WAITST, RESP} stateT;

  stateT             state;
  logic [3:0]        waitCnt;
  logic              latWe;
  logic [IDX_W-1:0]  latIdx;
  logic [DATA_W-1:0] latWdata;
  logic [BYTES-1:0]  latBe;
  logic              latErr;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              reqErr;
  logic [IDX_W-1:0]  reqIdx;

  // Access operands on the edge that enters RESP: straight from the request
  // when there are no wait states, otherwise from the latched copy.
  logic              enterResp;
  logic              curWe;
  logic [IDX_W-1:0]  curIdx;
  logic [DATA_W-1:0] curWdata;
  logic [BYTES-1:0]  curBe;
  logic              curErr;
  logic              memWrite;

  assign accept = (state == IDLE) && req_valid && req_ready;
  assign reqIdx = req_addr[OFF_W+IDX_W-1:OFF_W];
  assign reqErr = (req_addr[OFF_W-1:0] != '0) || ({1'b0, req_addr} >= LIMIT);

  always_comb begin
    enterResp = 1'b0;
    curWe     = latWe;
    curIdx    = latIdx;
    curWdata  = latWdata;
    curBe     = latBe;
    curErr    = latErr;
    if (state == IDLE) begin
      curWe     = req_we;
      curIdx    = reqIdx;
      curWdata  = req_wdata;
      curBe     = req_be;
      curErr    = reqErr;
      enterResp = accept && (WAIT == 0);
    end else if (state == WAITST) begin
      enterResp = (waitCnt == 4'd0);
    end
  end

  // Gated by reset so nothing lands in the array while reset is held.
  assign memWrite = enterResp && curWe && !curErr && reset;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (memWrite) begin
      for (int i = 0; i < BYTES; i++) begin
        if (curBe[i]) mem[curIdx][8*i +: 8] <= curWdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      waitCnt    <= 4'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      latWe      <= 1'b0;
      latIdx     <= '0;
      latWdata   <= '0;
      latBe      <= '0;
      latErr     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            latWe     <= req_we;
            latIdx    <= reqIdx;
            latWdata  <= req_wdata;
            latBe     <= req_be;
            latErr    <= reqErr;
            req_ready <= 1'b0;
            if (WAIT == 0) begin
              state <= RESP;
            end else begin
              state   <= WAITST;
              waitCnt <= 4'(WAIT - 1);
            end
          end
        end
        WAITST: begin
          if (waitCnt == 4'd0) state <= RESP;
          else waitCnt <= waitCnt - 4'd1;
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      // Read data is sampled before any same-edge write; reads never write anyway.
      if (enterResp) begin
        resp_valid <= 1'b1;
        resp_err   <= curErr;
        resp_rdata <= (curErr || curWe) ? '0 : mem[curIdx];
      end
    end
  end

endmodule
